// File: rtl/cc_pkg.sv
// Shared widths, FSM encodings and address layout for the read-only direct-mapped cache
// controller.
package cc_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 9;
    localparam int OFF_W  = 6;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int BEATS  = (2 ** OFF_W) * 8 / DATA_W;
    localparam int BEAT_W = $clog2(BEATS);

    typedef logic [3:0] state_t;

    localparam state_t S_INIT    = 4'd0;
    localparam state_t S_IDLE    = 4'd1;
    localparam state_t S_LOOKUP  = 4'd2;
    localparam state_t S_DATA    = 4'd3;
    localparam state_t S_RSP     = 4'd4;
    localparam state_t S_MISS_AR = 4'd5;
    localparam state_t S_REFILL  = 4'd6;
    localparam state_t S_TAG_WR  = 4'd7;
    localparam state_t S_REREAD  = 4'd8;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
    } addr_t;

endpackage

// File: rtl/cc_cache_ctrl.sv
// Main sequencer of the direct-mapped read-only cache: tag sweep after reset, lookup,
// hit read-out and 8-beat line refill.
module cc_cache_ctrl
    import cc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_data_o,
    output logic                hs_pulse_o,
    input  logic                hit_i,
    input  logic                miss_i,
    output logic                tag_rd_en_o,
    output logic                tag_wr_en_o,
    output logic [IDX_W-1:0]    tag_addr_o,
    output logic [TAG_W:0]      tag_wdata_o,
    output logic                data_rd_en_o,
    output logic                data_wr_en_o,
    output logic [IDX_W+2:0]    data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    input  logic [DATA_W-1:0]   data_rdata_i,
    output logic                mem_arvalid_o,
    input  logic                mem_arready_i,
    output logic [ADDR_W-1:0]   mem_araddr_o,
    output logic [7:0]          mem_arlen_o,
    input  logic                mem_rvalid_i,
    output logic                mem_rready_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_rlast_i
);

    state_t            state_q, state_d;
    // Set counter during the tag sweep, beat counter during a refill.
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    addr_t             addr_q, addr_d;
    addr_t             req_addr;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] word;

    assign req_addr = addr_t'(req_addr_i);
    assign beat     = cnt_q[BEAT_W-1:0];
    assign word     = addr_q.offset[OFF_W-1 -: BEAT_W];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        rsp_data_d    = rsp_data_q;
        req_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        rsp_data_o    = '0;
        hs_pulse_o    = 1'b0;
        tag_rd_en_o   = 1'b0;
        tag_wr_en_o   = 1'b0;
        tag_addr_o    = '0;
        tag_wdata_o   = '0;
        data_rd_en_o  = 1'b0;
        data_wr_en_o  = 1'b0;
        data_addr_o   = '0;
        data_wdata_o  = '0;
        mem_arvalid_o = 1'b0;
        mem_araddr_o  = '0;
        mem_arlen_o   = '0;
        mem_rready_o  = 1'b0;
        // Everything stays quiet while reset is held, including SRAM strobes.
        if (rst_n) begin
            rsp_data_o = rsp_data_q;
            case (state_q)
                S_INIT: begin
                    tag_wr_en_o = 1'b1;
                    tag_addr_o  = cnt_q;
                    cnt_d       = cnt_q + IDX_W'(1);
                    if (cnt_q == '1) state_d = S_IDLE;
                end
                S_IDLE: begin
                    req_ready_o = 1'b1;
                    if (req_valid_i) begin
                        hs_pulse_o  = 1'b1;
                        tag_rd_en_o = 1'b1;
                        tag_addr_o  = req_addr.index;
                        addr_d      = req_addr;
                        state_d     = S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_i) begin
                        data_rd_en_o = 1'b1;
                        data_addr_o  = {addr_q.index, word};
                        state_d      = S_DATA;
                    end else begin
                        state_d = S_MISS_AR;
                    end
                end
                S_DATA: begin
                    rsp_data_d = data_rdata_i;
                    state_d    = S_RSP;
                end
                S_RSP: begin
                    rsp_valid_o = 1'b1;
                    if (rsp_ready_i) state_d = S_IDLE;
                end
                S_MISS_AR: begin
                    mem_arvalid_o = 1'b1;
                    mem_araddr_o  = {addr_q.tag, addr_q.index, {OFF_W{1'b0}}};
                    mem_arlen_o   = 8'(BEATS - 1);
                    if (mem_arready_i) begin
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
                S_REFILL: begin
                    mem_rready_o = 1'b1;
                    if (mem_rvalid_i) begin
                        data_wr_en_o = 1'b1;
                        data_addr_o  = {addr_q.index, beat};
                        data_wdata_o = mem_rdata_i;
                        cnt_d        = cnt_q + IDX_W'(1);
                        if (beat == BEAT_W'(BEATS - 1)) state_d = S_TAG_WR;
                    end
                end
                S_TAG_WR: begin
                    tag_wr_en_o = 1'b1;
                    tag_addr_o  = addr_q.index;
                    tag_wdata_o = {1'b1, addr_q.tag};
                    state_d     = S_REREAD;
                end
                S_REREAD: begin
                    data_rd_en_o = 1'b1;
                    data_addr_o  = {addr_q.index, word};
                    state_d      = S_DATA;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            addr_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifndef SYNTHESIS
    a_hit_miss_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_LOOKUP) |-> (hit_i != miss_i));
    a_rlast_on_last_beat: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_REFILL && mem_rvalid_i) |-> (mem_rlast_i == (beat == BEAT_W'(BEATS - 1))));
`endif

endmodule

// File: doc/cc_cache_ctrl.md
Name: cc_cache_ctrl

Overview:
- Main sequencer for the direct-mapped, read-only cache: 32-bit address, 64 B lines, 512 sets.
- Accepts load requests, drives the tag SRAM read, and consumes hit/miss from the tag comparator.
- On a hit, reads the data SRAM and returns one 64-bit word.
- On a miss, issues an 8-beat line fill to memory, writes data and tag SRAMs, then serves the request.
- Sits between the request decoder/handshake front-end and the tag comparator, SRAMs and memory port.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 64, data SRAM / memory beat / response width.
- TAG_W, 17, tag width (ADDR_W-IDX_W-OFF_W).
- IDX_W, 9, set index width.
- OFF_W, 6, line offset width; BEATS = 2**OFF_W*8/DATA_W = 8 (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_i  in  ADDR_W  byte address {tag,index,offset}
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_data_o  out  DATA_W  word at offset[5:3]
- hs_pulse_o  out  1  req_valid_i&&req_ready_o, to comparator
- hit_i  in  1  comparator hit, valid cycle after hs_pulse_o
- miss_i  in  1  comparator miss, same timing
- tag_rd_en_o  out  1  tag SRAM read
- tag_wr_en_o  out  1  tag SRAM write
- tag_addr_o  out  IDX_W  tag SRAM set
- tag_wdata_o  out  TAG_W+1  {valid,tag}
- data_rd_en_o  out  1  data SRAM read, 1-cycle latency
- data_wr_en_o  out  1  data SRAM write
- data_addr_o  out  IDX_W+3  {index,beat}
- data_wdata_o  out  DATA_W  refill beat
- data_rdata_i  in  DATA_W  data SRAM read data
- mem_arvalid_o  out  1  line-fill request
- mem_arready_i  in  1  accept
- mem_araddr_o  out  ADDR_W  {tag,index,6'b0}
- mem_arlen_o  out  8  constant BEATS-1 (7)
- mem_rvalid_i  in  1  fill beat valid
- mem_rready_o  out  1  fill beat ready
- mem_rdata_i  in  DATA_W  fill beat
- mem_rlast_i  in  1  last beat

Behaviour:
- Reset: state=INIT, set counter=0, all outputs 0 (req_ready_o=0, rsp_valid_o=0, rsp_data_o=0). Reset mid-refill abandons the burst; the memory side shares rst_n.
- INIT: tag_wr_en_o=1, tag_addr_o=counter, tag_wdata_o=0, one set per cycle. After set 511 go to IDLE, i.e. 512 write cycles. req_ready_o=0 throughout.
- IDLE: req_ready_o=1.
  - On valid&&ready: latch addr; drive tag_rd_en_o=1, tag_addr_o=req_addr_i index combinationally; hs_pulse_o=1; go to LOOKUP.
- LOOKUP (1 cycle): sample hit_i/miss_i.
  - Hit: data_rd_en_o=1, data_addr_o={index,offset[5:3]}; go to DATA.
  - Miss: go to MISS_AR.
  - hit_i==miss_i is illegal (assertion).
- DATA: capture data_rdata_i into rsp_data_o; go to RSP.
- RSP: rsp_valid_o=1, rsp_data_o stable until rsp_ready_i. On accept go to IDLE; next request is accepted no earlier than the following cycle.
- Hit latency: accept at cycle N, rsp_valid_o at N+3.
- MISS_AR: mem_arvalid_o=1 with mem_araddr_o held constant until mem_arready_i. Then beat=0, go to REFILL.
- REFILL: mem_rready_o=1.
  - Each rvalid beat: data_wr_en_o=1, data_addr_o={index,beat}, data_wdata_o=mem_rdata_i, beat++.
  - Gaps (rvalid=0) hold state.
  - After beat 7 is written go to TAG_WR.
  - rlast must coincide with beat 7 (assertion); beat count is authoritative.
- TAG_WR: tag_wr_en_o=1, tag_wdata_o={1'b1,tag}. Then data_rd_en_o for the requested word next cycle (REREAD), then DATA, then RSP.
- Tag SRAM: never read and written in the same cycle.
- Data SRAM: never read and written in the same cycle.
- Request address: latched; req_addr_i is ignored outside IDLE.

Decomposition:
- Package cc_pkg holds:
  - widths (ADDR_W, TAG_W, IDX_W, OFF_W, DATA_W, BEATS);
  - state enum {S_INIT,S_IDLE,S_LOOKUP,S_DATA,S_RSP,S_MISS_AR,S_REFILL,S_TAG_WR,S_REREAD};
  - address-field typedef struct {tag,index,offset}.
- Single module; no sub-module needed. The INIT set counter and the refill beat counter share one IDX_W-bit register.

Test Plan:
- Reset, then idle: exactly 512 tag writes with addresses 0..511 and wdata 0; req_ready_o rises the cycle after the 512th write.
- Read 0x0000_1048 after init (cold miss): araddr=0x0000_1040, arlen=7; fill beats D0..D7. Writes land at data addr {0x041,0..7}; tag write {1,0x00000} at set 0x041. Response returns D1.
- Repeat read 0x0000_1050: no AR issued; rsp_valid_o 3 cycles after accept; data D2.
- Conflict miss at 0x0080_1040 (same index 0x041, tag 0x00100): new fill issued; tag rewritten {1,0x00100}.
- Backpressure: arready low 5 cycles, rvalid gaps of 2 cycles between beats, rsp_ready low 4 cycles. araddr and rsp_data_o stay stable; exactly 8 data writes.
- Assert rst_n low during REFILL beat 3: next cycle all outputs 0, state INIT, sweep restarts from set 0.
